// File: rtl/adc_uart_packetizer_if.sv
// rtl/adc_uart_packetizer_if.sv - byte stream from the packetizer to the UART transmitter
interface adc_uart_packetizer_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       error;

    modport master (output data, output valid, output error, input ready);
    modport slave  (input data, input valid, input error, output ready);
endinterface

// File: rtl/adc_uart_packetizer.sv
// rtl/adc_uart_packetizer.sv - buffers ADC samples and frames them into checksummed byte packets
module adc_uart_packetizer #(
    parameter int         SAMPLE_W        = 12,
    parameter int         SAMPLES_PER_PKT = 4,
    parameter int         FIFO_DEPTH      = 16,
    parameter logic [7:0] HEADER          = 8'hA5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [SAMPLE_W-1:0]               adc_data,
    input  logic                              adc_valid,
    adc_uart_packetizer_if.master             tx,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(SAMPLES_PER_PKT + 1);

    typedef enum logic [2:0] {IDLE, HDR, SEQ, SMP_HI, SMP_LO, CSUM} state_t;

    state_t              state, state_n;
    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic                full, push, pop, drop, xfer;
    logic                drop_pending;
    logic [7:0]          seq;
    logic [7:0]          csum, csum_n;
    logic [CW-1:0]       smp_cnt, smp_cnt_n;
    logic [7:0]          data_n;
    logic                valid_n, error_n, seq_inc;
    logic [SAMPLE_W-1:0] head, next_head;

    // Space is judged at the start of the cycle: a same-cycle pop never makes room.
    assign full      = (fifo_level == LW'(FIFO_DEPTH));
    assign push      = adc_valid && !full;
    assign drop      = adc_valid && full;
    assign xfer      = tx.valid && tx.ready;
    assign head      = mem[rd_ptr];
    assign next_head = mem[rd_ptr + AW'(1)];

    // Sample storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= adc_data;
    end

    // FIFO pointers, level and loss flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            overflow     <= 1'b0;
            drop_pending <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
            if (drop) overflow <= 1'b1;
            if (drop)
                drop_pending <= 1'b1;
            else if (state == CSUM && xfer)
                drop_pending <= 1'b0;
        end
    end

    // State register plus the registered byte-stream outputs and packet bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx.data  <= 8'h00;
            tx.valid <= 1'b0;
            tx.error <= 1'b0;
            csum     <= 8'h00;
            smp_cnt  <= '0;
            seq      <= 8'h00;
        end else begin
            state    <= state_n;
            tx.data  <= data_n;
            tx.valid <= valid_n;
            tx.error <= error_n;
            csum     <= csum_n;
            smp_cnt  <= smp_cnt_n;
            if (seq_inc) seq <= seq + 8'h01;
        end
    end

    // Next state and the byte to present next; each byte is loaded on the transfer of the previous one.
    always_comb begin
        state_n   = state;
        data_n    = tx.data;
        valid_n   = tx.valid;
        error_n   = tx.error;
        csum_n    = csum;
        smp_cnt_n = smp_cnt;
        pop       = 1'b0;
        seq_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_level >= LW'(SAMPLES_PER_PKT)) begin
                    state_n   = HDR;
                    data_n    = HEADER;
                    valid_n   = 1'b1;
                    error_n   = 1'b0;
                    csum_n    = 8'h00;
                    smp_cnt_n = '0;
                end
            end
            HDR: begin
                if (xfer) begin
                    state_n = SEQ;
                    data_n  = seq;
                end
            end
            SEQ: begin
                if (xfer) begin
                    state_n = SMP_HI;
                    csum_n  = csum + tx.data;
                    data_n  = 8'(head >> 8);
                end
            end
            SMP_HI: begin
                if (xfer) begin
                    state_n = SMP_LO;
                    csum_n  = csum + tx.data;
                    data_n  = head[7:0];
                end
            end
            SMP_LO: begin
                if (xfer) begin
                    pop    = 1'b1;
                    csum_n = csum + tx.data;
                    if (smp_cnt == CW'(SAMPLES_PER_PKT - 1)) begin
                        state_n = CSUM;
                        data_n  = csum + tx.data;
                        error_n = drop_pending;
                    end else begin
                        state_n   = SMP_HI;
                        smp_cnt_n = smp_cnt + CW'(1);
                        data_n    = 8'(next_head >> 8);
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_n = IDLE;
                    seq_inc = 1'b1;
                    data_n  = 8'h00;
                    valid_n = 1'b0;
                    error_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_adc_uart_packetizer.sv
// tb/tb_adc_uart_packetizer.sv - randomized self-checking bench for adc_uart_packetizer
module tb_adc_uart_packetizer;
    logic        clk;
    logic        reset;
    logic [11:0] adc_data;
    logic        adc_valid;
    logic        tx_ready;
    logic [4:0]  fifo_level;
    logic        overflow;

    adc_uart_packetizer_if tx_if ();
    assign tx_if.ready = tx_ready;

    adc_uart_packetizer dut (
        .clk        (clk),
        .reset      (reset),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .tx         (tx_if),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] obs_d [$];
    bit         obs_e [$];
    logic [7:0] exp_d [$];
    bit         exp_e [$];
    int         mq [$];
    int         model_seq = 0;
    int         drops = 0;
    bit         rand_ready = 0;
    int         ready_pct = 60;
    logic [7:0] basic_bytes [11] = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h04, 8'h56,
                                     8'h07, 8'h89, 8'h0A, 8'hBC, 8'hD4};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Byte monitor: records transfers and checks that stalled bytes hold.
    logic       stalled = 0;
    logic [7:0] prev_d;
    logic       prev_e;
    always @(negedge clk) begin
        if (reset) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                chk("stall_valid", 32'(tx_if.valid), 32'd1);
                chk("stall_data", 32'(tx_if.data), 32'(prev_d));
                chk("stall_error", 32'(tx_if.error), 32'(prev_e));
            end
            if (tx_if.valid && tx_ready) begin
                obs_d.push_back(tx_if.data);
                obs_e.push_back(tx_if.error);
            end
            stalled = tx_if.valid && !tx_ready;
            prev_d  = tx_if.data;
            prev_e  = tx_if.error;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) tx_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic push(input int v);
        adc_data  = 12'(v);
        adc_valid = 1'b1;
        step();
        adc_valid = 1'b0;
        if (mq.size() < 16) mq.push_back(v);
        else drops++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        mq.delete();
        obs_d.delete();
        obs_e.delete();
        exp_d.delete();
        exp_e.delete();
        model_seq = 0;
        drops = 0;
    endtask

    // Reference packet: header, sequence, hi/lo of each sample, then mod-256 sum excluding header.
    task automatic model_packet(input bit err);
        int sum;
        int s;
        exp_d.push_back(8'hA5);
        exp_e.push_back(1'b0);
        exp_d.push_back(8'(model_seq));
        exp_e.push_back(1'b0);
        sum = model_seq;
        for (int k = 0; k < 4; k++) begin
            s = mq.pop_front();
            exp_d.push_back(8'(s / 256));
            exp_e.push_back(1'b0);
            exp_d.push_back(8'(s % 256));
            exp_e.push_back(1'b0);
            sum = sum + s / 256 + s % 256;
        end
        exp_d.push_back(8'(sum % 256));
        exp_e.push_back(err);
        model_seq = (model_seq + 1) % 256;
    endtask

    task automatic load_basic();
        for (int i = 0; i < 11; i++) begin
            exp_d.push_back(basic_bytes[i]);
            exp_e.push_back(1'b0);
        end
    endtask

    task automatic compare_stream(input string tag, input int bound);
        int c = 0;
        while (obs_d.size() < exp_d.size() && c < bound) begin
            step();
            c++;
        end
        step();
        step();
        chk({tag, "_count"}, 32'(obs_d.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(obs_d[i]), 32'(exp_d[i]));
            chk($sformatf("%s_err%0d", tag, i), 32'(obs_e[i]), 32'(exp_e[i]));
        end
        obs_d.delete();
        obs_e.delete();
        exp_d.delete();
        exp_e.delete();
    endtask

    initial begin
        int c;
        reset     = 1'b0;
        adc_data  = '0;
        adc_valid = 1'b0;
        tx_ready  = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_valid", 32'(tx_if.valid), 32'd0);
        chk("rst_data", 32'(tx_if.data), 32'd0);
        chk("rst_error", 32'(tx_if.error), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        do_reset();

        // Basic packet with the documented byte image.
        push(12'h123);
        push(12'h456);
        push(12'h789);
        push(12'hABC);
        chk("basic_level4", 32'(fifo_level), 32'd4);
        chk("basic_valid_low", 32'(tx_if.valid), 32'd0);
        step();
        chk("basic_valid_rise", 32'(tx_if.valid), 32'd1);
        chk("basic_first_byte", 32'(tx_if.data), 32'hA5);
        load_basic();
        compare_stream("basic", 100);
        chk("basic_level0", 32'(fifo_level), 32'd0);

        // Same samples under random backpressure from a fresh reset.
        do_reset();
        rand_ready = 1;
        ready_pct  = 50;
        push(12'h123);
        push(12'h456);
        push(12'h789);
        push(12'hABC);
        load_basic();
        compare_stream("bp", 500);
        rand_ready = 0;
        tx_ready   = 1'b1;
        mq.delete();
        model_seq = 1;

        // Partial fill holds off the packet until the last sample lands.
        for (int i = 0; i < 3; i++) push(int'($urandom_range(0, 4095)));
        for (int i = 0; i < 5; i++) step();
        chk("partial_valid", 32'(tx_if.valid), 32'd0);
        chk("partial_level", 32'(fifo_level), 32'd3);
        push(int'($urandom_range(0, 4095)));
        chk("partial_level4", 32'(fifo_level), 32'd4);
        chk("partial_wait", 32'(tx_if.valid), 32'd0);
        step();
        chk("partial_start", 32'(tx_if.valid), 32'd1);
        model_packet(1'b0);
        compare_stream("partial", 100);

        // Overflow with the transmitter stalled.
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 20; i++) push(int'($urandom_range(0, 4095)));
        step();
        chk("ovf_level", 32'(fifo_level), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drops_seen", 32'(drops), 32'd4);
        tx_ready = 1'b1;
        for (int p = 0; p < 4; p++) model_packet(p == 0 && drops > 0);
        compare_stream("ovf", 300);
        chk("ovf_level0", 32'(fifo_level), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset after the SEQ byte of a packet abandons it and restarts numbering.
        for (int i = 0; i < 4; i++) push(int'($urandom_range(0, 4095)));
        c = 0;
        while (obs_d.size() < 2 && c < 100) begin
            step();
            c++;
        end
        chk("mid_seen2", 32'(obs_d.size()), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_valid", 32'(tx_if.valid), 32'd0);
        chk("mid_level", 32'(fifo_level), 32'd0);
        chk("mid_overflow", 32'(overflow), 32'd0);
        if (obs_d.size() >= 2) begin
            chk("mid_hdr", 32'(obs_d[0]), 32'hA5);
            chk("mid_seq", 32'(obs_d[1]), 32'(model_seq));
        end
        do_reset();
        for (int i = 0; i < 4; i++) push(int'($urandom_range(0, 4095)));
        model_packet(1'b0);
        compare_stream("after_rst", 100);

        // 257 packets across the sequence wrap, with random backpressure.
        do_reset();
        rand_ready = 1;
        ready_pct  = 70;
        for (int p = 0; p < 257; p++) begin
            for (int i = 0; i < 4; i++) push(int'($urandom_range(0, 4095)));
            model_packet(1'b0);
            compare_stream($sformatf("wrap%0d", p), 400);
        end
        rand_ready = 0;
        chk("wrap_overflow", 32'(overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
